// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared constants and types for the RV32I ALU issue stage.
//
// Contents:
//   XLEN                      datapath width (RV32 only)
//   OPC_*                     major opcodes decoded by the issue stage
//   ALU_*                     ALU operation codes, equal to the RV32I funct3 values
//   issue_t                   one decoded entry as presented to the ALU
//   skid_state_t              occupancy of the 2-entry skid buffer
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      op;
    logic            sub;
    logic            sra;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } issue_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec -- combinational decoder for the ALU-class RV32I opcodes.
//
// Ports:
//   instr  in   32    instruction word
//   pc     in   XLEN  instruction address (AUIPC operand)
//   rs1    in   XLEN  rs1 read data
//   rs2    in   XLEN  rs2 read data
//   dec    out  issue_t  decoded operands/controls; illegal entries carry
//                        only illegal=1 with every other field zero
module alu_issue_dec
  import riscv_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output issue_t        dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] shamt;
  logic            alt_f7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign u_imm  = {instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign alt_f7 = (funct7 == F7_ALT);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned and no latch is inferred.
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.we      = 1'b1;
    dec.illegal = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        dec.a   = rs1;
        dec.b   = rs2;
        dec.op  = funct3;
        dec.sub = (funct3 == ALU_ADD) && instr[30];
        dec.sra = (funct3 == ALU_SR)  && instr[30];
        // The alternate funct7 only exists for SUB and SRA.
        if (!((funct7 == F7_BASE) ||
              (alt_f7 && ((funct3 == ALU_ADD) || (funct3 == ALU_SR))))) begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.a  = rs1;
        dec.op = funct3;
        if (funct3 == ALU_SLL) begin
          dec.b = shamt;
          if (funct7 != F7_BASE) dec.illegal = 1'b1;
        end else if (funct3 == ALU_SR) begin
          dec.b   = shamt;
          dec.sra = instr[30];
          if (!((funct7 == F7_BASE) || alt_f7)) dec.illegal = 1'b1;
        end else begin
          dec.b = i_imm;
        end
      end
      OPC_LUI: begin
        dec.b = u_imm;
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = u_imm;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal entries still flow down the pipe, but must not write back or
    // leak operand data.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- decode/issue stage in front of the RV32I ALU.
//
// Accepts instruction + register read data on a valid/ready handshake,
// decodes it (alu_issue_dec) and holds it in a 2-entry skid buffer so that
// in_ready is a pure function of registered state while still sustaining one
// instruction per cycle.
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   in_valid/in_ready                 upstream handshake
//   in_instr, in_pc, in_rs1, in_rs2   instruction, its address, operand data
//   out_valid/out_ready               downstream handshake
//   out_a, out_b, out_op, out_sub,    ALU operands and controls
//   out_sra
//   out_rd, out_we, out_illegal       destination, write enable, decode fault
//   perf_issued, perf_illegal         saturating counters, only when
//                                     ALU_ISSUE_PERF_EN is defined
module alu_issue
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_op,
  output logic            out_sub,
  output logic            out_sra,
  output logic [4:0]      out_rd,
  output logic            out_we,
`ifdef ALU_ISSUE_PERF_EN
  output logic            out_illegal,
  output logic [31:0]     perf_issued,
  output logic [15:0]     perf_illegal
`else
  output logic            out_illegal
`endif
);

  skid_state_t state;
  issue_t      dec;
  issue_t      out_q;   // entry presented to the ALU
  issue_t      skid_q;  // second entry, parked while the output stalls
  logic        in_fire;
  logic        out_fire;

  alu_issue_dec u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .dec   (dec)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: both buffer entries are reset, not just the state, so every out_*
  // reads 0 during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge values of state/out_q/skid_q.
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            out_q <= dec;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_q <= dec;
            state  <= FULL;
          end else if (!in_fire && out_fire) begin
            state <= EMPTY;
          end else if (in_fire && out_fire) begin
            out_q <= dec;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            out_q <= skid_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_op      = out_q.op;
  assign out_sub     = out_q.sub;
  assign out_sra     = out_q.sra;
  assign out_rd      = out_q.rd;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued  <= '0;
      perf_illegal <= '0;
    end else if (out_fire) begin
      if (perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (out_q.illegal && (perf_illegal != '1)) perf_illegal <= perf_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- self-checking bench for alu_issue.
// A queue models the two-entry buffer: occupancy gives in_ready/out_valid,
// and each entry is decoded from the instruction-set rules when accepted.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic        out_sub;
  logic        out_sra;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [15:0] perf_illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sub;
    logic        sra;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic last_in_fire;
  int   exp_issued;
  int   exp_illegal;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_op      (out_op),
    .out_sub     (out_sub),
    .out_sra     (out_sra),
    .out_rd      (out_rd),
    .out_we      (out_we),
`ifdef ALU_ISSUE_PERF_EN
    .out_illegal (out_illegal),
    .perf_issued (perf_issued),
    .perf_illegal(perf_illegal)
`else
    .out_illegal (out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    int unsigned opc, f3, f7;
    bit ok;
    opc = ins & 32'h7F;
    f3  = (ins >> 12) & 7;
    f7  = ins >> 25;
    e   = '{a: 0, b: 0, op: 0, sub: 0, sra: 0, rd: 0, ill: 0};
    ok  = 1'b0;
    if (opc == 32'h33) begin
      ok    = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      e.a   = rs1;
      e.b   = rs2;
      e.op  = 3'(f3);
      e.sub = (f3 == 0) && (f7 == 32);
      e.sra = (f3 == 5) && (f7 == 32);
    end else if (opc == 32'h13) begin
      e.a  = rs1;
      e.op = 3'(f3);
      if (f3 == 1 || f3 == 5) begin
        e.b   = (ins >> 20) & 31;
        e.sra = (f3 == 5) && (f7 == 32);
        ok    = (f3 == 1) ? (f7 == 0) : (f7 == 0 || f7 == 32);
      end else begin
        e.b = 32'($signed(ins) >>> 20);
        ok  = 1'b1;
      end
    end else if (opc == 32'h37 || opc == 32'h17) begin
      e.a = (opc == 32'h17) ? pc : 32'd0;
      e.b = ins & 32'hFFFF_F000;
      ok  = 1'b1;
    end
    e.rd = 5'((ins >> 7) & 31);
    if (!ok) e = '{a: 0, b: 0, op: 0, sub: 0, sra: 0, rd: 0, ill: 1};
    return e;
  endfunction

  // One clock: compare at the falling edge, then update the model at the
  // rising edge. Returns 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    bit   ifire, ofire;
    @(negedge clk);
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      check("out_illegal", out_illegal, e.ill);
      check("out_we", out_we, !e.ill);
      check("out_a", out_a, e.a);
      check("out_b", out_b, e.b);
      if (!e.ill) begin
        check("out_op", out_op, e.op);
        check("out_sub", out_sub, e.sub);
        check("out_sra", out_sra, e.sra);
        check("out_rd", out_rd, e.rd);
      end
    end
    ifire = in_valid && (q.size() < 2);
    ofire = out_ready && (q.size() > 0);
    e = ref_dec(in_instr, in_pc, in_rs1, in_rs2);
    @(posedge clk);
    if (ofire) begin
      if (q[0].ill) exp_illegal++;
      exp_issued++;
      void'(q.pop_front());
    end
    if (ifire) q.push_back(e);
    last_in_fire = ifire;
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = $urandom;
    in_rs1   = rs1;
    in_rs2   = rs2;
  endtask

  // Issue one instruction into an empty stage, leave it presented.
  task automatic issue1(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    out_ready = 1'b0;
    drive(ins, rs1, rs2);
    step();
    in_valid = 1'b0;
    #3;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3) begin
      r[6:0] = 7'h33;
      r[31:25] = f7;
    end else if (k <= 6) begin
      r[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 1) r[31:25] = f7;
    end else if (k == 7) begin
      r[6:0] = 7'h37;
    end else if (k == 8) begin
      r[6:0] = 7'h17;
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    last_in_fire = 1'b0; exp_issued = 0; exp_illegal = 0;
    #12;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_a", out_a, 0);
    check("rst out_we", out_we, 0);
    #5 rst_n = 1'b1;

    // ADD x3,x1,x2
    issue1(32'h002081B3, 5, 7);
    check("add a", out_a, 5);
    check("add b", out_b, 7);
    check("add rd", out_rd, 3);
    check("add we", out_we, 1);
    out_ready = 1'b1; step();
    // SUB then SRAI x5,x6,4
    issue1(32'h402081B3, 9, 4);
    check("sub sub", out_sub, 1);
    out_ready = 1'b1; step();
    issue1(32'h40435293, 32'h8000_0000, 0);
    check("srai op", out_op, 5);
    check("srai sra", out_sra, 1);
    check("srai b", out_b, 4);
    check("srai a", out_a, 32'h8000_0000);
    check("srai rd", out_rd, 5);
    out_ready = 1'b1; step();
    // ADDI x1,x0,-1 and LUI x7,0x12345
    issue1(32'hFFF00093, 0, 0);
    check("addi b", out_b, 32'hFFFF_FFFF);
    check("addi sub", out_sub, 0);
    out_ready = 1'b1; step();
    issue1(32'h123453B7, 1, 2);
    check("lui a", out_a, 0);
    check("lui b", out_b, 32'h1234_5000);
    check("lui rd", out_rd, 7);
    out_ready = 1'b1; step();

    // Illegal entries back to back, in order, no stall.
    out_ready = 1'b1;
    drive(32'h0000007F, 1, 2); step();
    drive(32'h40009093, 3, 4); step();
    check("ill1 flag", out_illegal, 1);
    check("ill1 we", out_we, 0);
    in_valid = 1'b0; step();
    step();

    // Backpressure: three back-to-back, only two accepted.
    out_ready = 1'b0;
    drive(32'h00100093, 0, 0); step();      // ADDI x1
    drive(32'h00200113, 0, 0); step();      // ADDI x2
    check("bp in_ready", in_ready, 0);
    drive(32'h00300193, 0, 0); step();      // ADDI x3, held
    check("bp held", last_in_fire, 0);
    step();
    out_ready = 1'b1;
    step();                                  // x1 leaves, x3 still held
    check("bp rd2", out_rd, 2);
    step();                                  // x2 leaves, x3 accepted
    in_valid = 1'b0;
    check("bp rd3", out_rd, 3);
    step();                                  // x3 leaves
    check("bp drained", out_valid, 0);

    // Async reset while FULL.
    out_ready = 1'b0;
    drive(32'h00100093, 0, 0); step();
    drive(32'h00200113, 0, 0); step();
    in_valid = 1'b0;
    check("pre-rst in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 0);
    check("async in_ready", in_ready, 1);
    check("async out_rd", out_rd, 0);
    q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    exp_issued = 0; exp_illegal = 0;
    issue1(32'h00500293, 0, 0);              // ADDI x5,x0,5
    check("post-rst valid", out_valid, 1);
    check("post-rst b", out_b, 5);
    out_ready = 1'b1; step();

    // Randomized traffic against the model.
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_in_fire)) begin
        if ($urandom_range(0, 3) != 0) drive(rand_instr(), $urandom, $urandom);
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("final drained", out_valid, 0);

`ifdef ALU_ISSUE_PERF_EN
    check("perf_issued", perf_issued, exp_issued);
    check("perf_illegal", perf_illegal, exp_illegal);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Decode/issue stage directly upstream of the RV32I ALU. It accepts a fetched instruction plus register-file read data over a valid/ready handshake. It decodes the ALU-class opcodes and produces registered ALU operands and controls (a, b, op, sub, sra) together with the destination register. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
XLEN, 32, datapath width; only 32 is supported (RV32 shamt rules).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; high when state != FULL
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address (used by AUIPC)
in_rs1  in  XLEN  rs1 read data, valid with in_valid
in_rs2  in  XLEN  rs2 read data, valid with in_valid
out_valid  out  1  issued entry valid
out_ready  in  1  ALU/writeback consumer ready
out_a  out  XLEN  ALU operand a
out_b  out  XLEN  ALU operand b
out_op  out  3  ALU funct3 op (000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and)
out_sub  out  1  subtract select (op 000)
out_sra  out  1  arithmetic shift select (op 101)
out_rd  out  5  destination register
out_we  out  1  register write enable
out_illegal  out  1  instruction not decodable by this stage

Behaviour:
- Reset (async, rst_n low): state EMPTY; all out_* are 0; in_ready is 1, but no transfer occurs while rst_n is low. Reset mid-operation discards both buffer entries.
- Transfers: in fires on in_valid & in_ready; out fires on out_valid & out_ready.
- Latency: into EMPTY, an instruction accepted at edge k is presented at k+1. Throughput is 1/cycle. Order is preserved.
- States and outputs:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: in fire -> ONE.
  - ONE: in fire without out fire -> FULL (new entry goes to skid). Out fire without in fire -> EMPTY. Both fire -> ONE (new entry replaces output).
  - FULL: out fire -> ONE (skid entry moves to output). in fire is impossible.
- Outputs are stable while out_valid=1 and out_ready=0.
- Decode, by opcode:
  - OP (0110011): a=rs1, b=rs2, op=funct3. sub=instr[30] only for funct3=000; sra=instr[30] only for funct3=101. funct7 must be 0000000, or 0100000 only when funct3 is 000 or 101; otherwise illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-immediate, op=funct3, sub=0 always.
    - Shifts (001/101): b=zero-extended instr[24:20]; sra=instr[30] (101 only).
    - SLLI requires funct7=0000000; SRLI/SRAI require funct7 in {0000000, 0100000}; otherwise illegal.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, op=000, sub=0.
  - AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, op=000, sub=0.
  - Anything else: illegal.
- Illegal entries are still issued in order: out_illegal=1, out_we=0, out_a/out_b=0.
- out_we=1 for every legal instruction, including rd=0. Suppressing writes to x0 is the register file's job.

Optional Feature:
ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] and perf_illegal[15:0], reset to 0. perf_issued increments on every out fire; perf_illegal increments on out fire with out_illegal=1. Both saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants: OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - ALU op constants: ALU_ADD..ALU_AND, matching the funct3 encoding above;
  - typedef issue_t: a, b, op, sub, sra, rd, we, illegal;
  - skid state enum: EMPTY, ONE, FULL.
- Sub-module alu_issue_dec: purely combinational, instr/pc/rs1/rs2 -> issue_t. The top module holds the skid buffer and FSM.

Test Plan:
- ADD x3,x1,x2: instr 0x002081B3, rs1=5, rs2=7 -> next cycle out_a=5, out_b=7, op=000, sub=0, rd=3, we=1, illegal=0.
- SUB 0x402081B3; SRAI x5,x6,4 (0x40435293, rs1=0x80000000) -> sub=1, then op=101, sra=1, b=4, a=0x80000000, rd=5.
- ADDI x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, sub=0; LUI x7,0x12345 (0x123453B7) -> a=0, b=0x12345000, rd=7.
- Illegal: 0x0000007F, and SLLI with funct7=0100000 (0x40009093) -> out_illegal=1, out_we=0, issued in order.
- Backpressure: out_ready=0 with three back-to-back instrs -> two accepted, in_ready=0 from the second edge, third held. Raise out_ready -> all three emerge in order, one per cycle, with no bubble.
- Assert rst_n low while FULL -> out_valid=0 immediately (async), in_ready=1; first instruction after release appears one cycle after acceptance.
